// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/DECODE/EXEC multi-cycle machine over a synchronous instruction ROM.
// Optional macro ACC_CPU_ILLEGAL_TRAP_EN turns opcode 15 into a trap that sets err and halts.
module acc_cpu_core #(
    parameter  int DATA_W  = 8,
    parameter  int NREG    = 4,
    parameter  int PC_W    = 6,
    localparam int RA_W    = $clog2(NREG),
    localparam int INSTR_W = 4 + RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  acc,
    output logic               halted,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_LDR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_JZ   = 4'd11;
    localparam logic [3:0] OP_JC   = 4'd12;
    localparam logic [3:0] OP_OUT  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_acc;
    logic               r_z;
    logic               r_c;
    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_halted;
    logic [DATA_W-1:0]  r_regs [NREG];

    logic [3:0]         w_op;
    logic [RA_W-1:0]    w_ra;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_rv;
    logic [DATA_W:0]    w_wide;
    logic [DATA_W-1:0]  w_acc_n;
    logic               w_z_n;
    logic               w_c_n;
    logic               w_setz;
    logic               w_jump;
    logic               w_trap;

    assign w_op  = r_ir[INSTR_W-1 -: 4];
    assign w_ra  = r_ir[DATA_W +: RA_W];
    assign w_imm = r_ir[DATA_W-1:0];
    assign w_rv  = r_regs[w_ra];

    assign imem_addr = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign acc       = r_acc;
    assign halted    = r_halted;

    // Datapath for the instruction held in IR; only committed in EXEC.
    always_comb begin
        w_wide  = '0;
        w_acc_n = r_acc;
        w_z_n   = r_z;
        w_c_n   = r_c;
        w_setz  = 1'b0;
        w_jump  = 1'b0;
        w_trap  = 1'b0;
        case (w_op)
            OP_LDI: begin w_acc_n = w_imm; w_setz = 1'b1; end
            OP_LDR: begin w_acc_n = w_rv;  w_setz = 1'b1; end
            OP_ADD: begin
                w_wide  = {1'b0, r_acc} + {1'b0, w_rv};
                w_acc_n = w_wide[DATA_W-1:0];
                w_c_n   = w_wide[DATA_W];
                w_setz  = 1'b1;
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow
                w_wide  = {1'b0, r_acc} - {1'b0, w_rv};
                w_acc_n = w_wide[DATA_W-1:0];
                w_c_n   = w_wide[DATA_W];
                w_setz  = 1'b1;
            end
            OP_AND: begin w_acc_n = r_acc & w_rv; w_setz = 1'b1; end
            OP_OR:  begin w_acc_n = r_acc | w_rv; w_setz = 1'b1; end
            OP_XOR: begin w_acc_n = r_acc ^ w_rv; w_setz = 1'b1; end
            OP_SHL: begin
                w_acc_n = {r_acc[DATA_W-2:0], 1'b0};
                w_c_n   = r_acc[DATA_W-1];
                w_setz  = 1'b1;
            end
            OP_JMP: w_jump = 1'b1;
            OP_JZ:  w_jump = r_z;
            OP_JC:  w_jump = r_c;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
            OP_ILL: w_trap = 1'b1;
`endif
            default: ;
        endcase
        if (w_setz) w_z_n = (w_acc_n == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_ir        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_acc   <= '0;
                        r_z     <= 1'b0;
                        r_c     <= 1'b0;
                    end
                end
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_acc <= w_acc_n;
                    r_z   <= w_z_n;
                    r_c   <= w_c_n;
                    if (w_op == OP_MOV) r_regs[w_ra] <= r_acc;
                    if (w_op == OP_OUT) begin
                        r_out_data  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                    // HALT and trap leave PC on the offending instruction
                    if (w_op == OP_HALT || w_trap) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_jump ? w_imm[PC_W-1:0] : r_pc + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!start) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_err <= 1'b0;
        else if (r_state == S_IDLE && start)     r_err <= 1'b0;
        else if (r_state == S_EXEC && w_trap)    r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
